// File: rtl/metadata_assoc_array_pkg.sv
// Shared defaults and FSM encoding for the set-associative cache metadata array.
package metadata_assoc_array_pkg;

    localparam int DEF_NUM_SETS = 64;
    localparam int DEF_NUM_WAYS = 2;
    localparam int DEF_TAG_W    = 6;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/metadata_assoc_array_set.sv
// One set: per-way valid/tag/age storage, tag compare, victim select and true-LRU update.
module metadata_assoc_array_set
    import metadata_assoc_array_pkg::*;
#(
    parameter int NUM_WAYS = DEF_NUM_WAYS,
    parameter int TAG_W    = DEF_TAG_W,
    parameter int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init_i,
    input  logic             upd_en_i,
    input  logic             wr_en_i,
    input  logic [WAY_W-1:0] upd_way_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             hit_o,
    output logic [WAY_W-1:0] hit_way_o,
    output logic [WAY_W-1:0] victim_way_o
);

    logic [NUM_WAYS-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q [NUM_WAYS];
    logic [TAG_W-1:0]    tag_d [NUM_WAYS];
    logic [WAY_W-1:0]    age_q [NUM_WAYS];
    logic [WAY_W-1:0]    age_d [NUM_WAYS];
    logic [WAY_W-1:0]    old_age_s;
    logic                inv_found_s;

    // Tag compare across valid ways
    always_comb begin
        hit_o     = 1'b0;
        hit_way_o = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[w] && (tag_q[w] == tag_i)) begin
                hit_o     = 1'b1;
                hit_way_o = WAY_W'(w);
            end else begin
                hit_o     = hit_o;
            end
        end
    end

    // Victim: lowest invalid way wins over the LRU way
    always_comb begin
        victim_way_o = '0;
        inv_found_s  = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (age_q[w] == WAY_W'(NUM_WAYS - 1)) begin
                victim_way_o = WAY_W'(w);
            end else begin
                victim_way_o = victim_way_o;
            end
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!inv_found_s && !valid_q[w]) begin
                victim_way_o = WAY_W'(w);
                inv_found_s  = 1'b1;
            end else begin
                inv_found_s  = inv_found_s;
            end
        end
    end

    // Next state: reinitialise, or promote upd_way to MRU (optionally writing its tag)
    always_comb begin
        valid_d   = valid_q;
        tag_d     = tag_q;
        age_d     = age_q;
        old_age_s = age_q[upd_way_i];
        if (init_i) begin
            valid_d = '0;
            for (int w = 0; w < NUM_WAYS; w++) begin
                tag_d[w] = '0;
                age_d[w] = WAY_W'(w);
            end
        end else if (upd_en_i) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (WAY_W'(w) == upd_way_i) begin
                    age_d[w] = '0;
                end else if (age_q[w] < old_age_s) begin
                    age_d[w] = age_q[w] + WAY_W'(1);
                end else begin
                    age_d[w] = age_q[w];
                end
            end
            if (wr_en_i) begin
                valid_d[upd_way_i] = 1'b1;
                tag_d[upd_way_i]   = tag_i;
            end else begin
                valid_d = valid_d;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Storage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int w = 0; w < NUM_WAYS; w++) begin
                tag_q[w] <= '0;
                age_q[w] <= WAY_W'(w);
            end
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            age_q   <= age_d;
        end
    end

endmodule

// File: rtl/metadata_assoc_array.sv
// N-way set-associative tag/valid/LRU array with registered lookup and a one-set-per-cycle flush.
module metadata_assoc_array
    import metadata_assoc_array_pkg::*;
#(
    parameter  int NUM_SETS = DEF_NUM_SETS,
    parameter  int NUM_WAYS = DEF_NUM_WAYS,
    parameter  int TAG_W    = DEF_TAG_W,
    localparam int IDX_W    = $clog2(NUM_SETS),
    localparam int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lookup_en,
    input  logic [IDX_W-1:0] index,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             fill_en,
    input  logic             flush_req,
    output logic             hit,
    output logic [WAY_W-1:0] hit_way,
    output logic [WAY_W-1:0] victim_way,
    output logic             busy,
    output logic             flush_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SETS - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               hit_q, hit_d;
    logic [WAY_W-1:0]   hit_way_q, hit_way_d;
    logic [WAY_W-1:0]   victim_q, victim_d;

    logic [NUM_SETS-1:0] set_hit_s;
    logic [WAY_W-1:0]    set_hit_way_s [NUM_SETS];
    logic [WAY_W-1:0]    set_victim_s  [NUM_SETS];
    logic                idle_s;
    logic                fill_go_s;
    logic                lu_upd_s;

    // A same-cycle fill owns the LRU update; the lookup's promotion is dropped
    always_comb begin
        idle_s    = (state_q == ST_IDLE);
        fill_go_s = fill_en && idle_s;
        lu_upd_s  = lookup_en && idle_s && set_hit_s[index] && !fill_go_s;
    end

    for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
        logic             sel_s;
        logic             init_s;
        logic             upd_en_s;
        logic [WAY_W-1:0] upd_way_s;

        assign sel_s     = (index == IDX_W'(s));
        assign init_s    = (state_q == ST_FLUSH) && (cnt_q == IDX_W'(s));
        assign upd_en_s  = sel_s && (fill_go_s || lu_upd_s);
        assign upd_way_s = fill_go_s ? set_victim_s[s] : set_hit_way_s[s];

        metadata_assoc_array_set #(
            .NUM_WAYS (NUM_WAYS),
            .TAG_W    (TAG_W),
            .WAY_W    (WAY_W)
        ) u_set (
            .clk          (clk),
            .rst          (rst),
            .init_i       (init_s),
            .upd_en_i     (upd_en_s),
            .wr_en_i      (fill_go_s),
            .upd_way_i    (upd_way_s),
            .tag_i        (tag_in),
            .hit_o        (set_hit_s[s]),
            .hit_way_o    (set_hit_way_s[s]),
            .victim_way_o (set_victim_s[s])
        );
    end

    // Flush sequencer next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (flush_req) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Lookup result capture; outputs hold when no lookup is issued
    always_comb begin
        hit_d     = hit_q;
        hit_way_d = hit_way_q;
        victim_d  = victim_q;
        if (lookup_en) begin
            if (idle_s) begin
                hit_d     = set_hit_s[index];
                hit_way_d = set_hit_way_s[index];
                victim_d  = set_victim_s[index];
            end else begin
                hit_d     = 1'b0;
                hit_way_d = '0;
                victim_d  = '0;
            end
        end else begin
            hit_d = hit_q;
        end
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hit_q     <= 1'b0;
            hit_way_q <= '0;
            victim_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hit_q     <= hit_d;
            hit_way_q <= hit_way_d;
            victim_q  <= victim_d;
        end
    end

    assign hit        = hit_q;
    assign hit_way    = hit_way_q;
    assign victim_way = victim_q;
    assign busy       = (state_q == ST_FLUSH);
    assign flush_done = (state_q == ST_FLUSH) && (cnt_q == LAST_IDX);

endmodule

// File: tb/tb_metadata_assoc_array.sv
// Scoreboard bench: 2-way/64-set instance plus a 4-way/4-set instance, directed vectors.
module tb_metadata_assoc_array;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       lookup_en_a, fill_en_a, flush_req_a;
    logic [5:0] index_a, tag_a;
    logic       hit_a, busy_a, done_a;
    logic [0:0] hit_way_a, victim_a;

    logic       lookup_en_b, fill_en_b, flush_req_b;
    logic [1:0] index_b;
    logic [5:0] tag_b;
    logic       hit_b, busy_b, done_b;
    logic [1:0] hit_way_b, victim_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       hit;
        logic [1:0] way;
        logic [1:0] vic;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    logic lu_v_a = 1'b0;
    logic lu_v_b = 1'b0;

    metadata_assoc_array dut_a (
        .clk(clk), .rst(rst), .lookup_en(lookup_en_a), .index(index_a), .tag_in(tag_a),
        .fill_en(fill_en_a), .flush_req(flush_req_a), .hit(hit_a), .hit_way(hit_way_a),
        .victim_way(victim_a), .busy(busy_a), .flush_done(done_a)
    );

    metadata_assoc_array #(.NUM_SETS(4), .NUM_WAYS(4), .TAG_W(6)) dut_b (
        .clk(clk), .rst(rst), .lookup_en(lookup_en_b), .index(index_b), .tag_in(tag_b),
        .fill_en(fill_en_b), .flush_req(flush_req_b), .hit(hit_b), .hit_way(hit_way_b),
        .victim_way(victim_b), .busy(busy_b), .flush_done(done_b)
    );

    // A lookup sampled on a rising edge yields a result visible at the next falling edge
    always @(posedge clk) begin
        lu_v_a <= lookup_en_a && !rst;
        lu_v_b <= lookup_en_b && !rst;
    end

    always @(negedge clk) begin
        if (lu_v_a) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL lookup_a: response with no expected entry");
            end else begin
                ea = q_a.pop_front();
                if (hit_a !== ea.hit || {1'b0, hit_way_a} !== ea.way || {1'b0, victim_a} !== ea.vic) begin
                    errors++;
                    $display("FAIL lookup_a: got hit=%0b way=%0d vic=%0d, want hit=%0b way=%0d vic=%0d",
                             hit_a, hit_way_a, victim_a, ea.hit, ea.way, ea.vic);
                end
            end
        end
        if (lu_v_b) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL lookup_b: response with no expected entry");
            end else begin
                eb = q_b.pop_front();
                if (hit_b !== eb.hit || hit_way_b !== eb.way || victim_b !== eb.vic) begin
                    errors++;
                    $display("FAIL lookup_b: got hit=%0b way=%0d vic=%0d, want hit=%0b way=%0d vic=%0d",
                             hit_b, hit_way_b, victim_b, eb.hit, eb.way, eb.vic);
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic lk_a(int idx, int tg, logic h, int w, int v);
        index_a     = 6'(idx);
        tag_a       = 6'(tg);
        lookup_en_a = 1'b1;
        q_a.push_back('{h, 2'(w), 2'(v)});
        @(posedge clk);
        #1 lookup_en_a = 1'b0;
    endtask

    task automatic fill_a(int idx, int tg);
        index_a   = 6'(idx);
        tag_a     = 6'(tg);
        fill_en_a = 1'b1;
        @(posedge clk);
        #1 fill_en_a = 1'b0;
    endtask

    task automatic lk_b(int idx, int tg, logic h, int w, int v);
        index_b     = 2'(idx);
        tag_b       = 6'(tg);
        lookup_en_b = 1'b1;
        q_b.push_back('{h, 2'(w), 2'(v)});
        @(posedge clk);
        #1 lookup_en_b = 1'b0;
    endtask

    task automatic fill_b(int idx, int tg);
        index_b   = 2'(idx);
        tag_b     = 6'(tg);
        fill_en_b = 1'b1;
        @(posedge clk);
        #1 fill_en_b = 1'b0;
    endtask

    int busy_cnt, done_cnt, done_at;

    initial begin
        rst = 1'b1;
        lookup_en_a = 1'b0; fill_en_a = 1'b0; flush_req_a = 1'b0; index_a = '0; tag_a = '0;
        lookup_en_b = 1'b0; fill_en_b = 1'b0; flush_req_b = 1'b0; index_b = '0; tag_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hit", 32'(hit_a), 32'd0);
        chk("rst_hit_way", 32'(hit_way_a), 32'd0);
        chk("rst_victim", 32'(victim_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_flush_done", 32'(done_a), 32'd0);
        rst = 1'b0;

        // Basic miss, fill, hit
        lk_a(5, 'h2A, 1'b0, 0, 0);
        fill_a(5, 'h2A);
        lk_a(5, 'h2A, 1'b1, 0, 1);

        // Two-way LRU replacement in set 3
        fill_a(3, 'h01);
        fill_a(3, 'h02);
        lk_a(3, 'h01, 1'b1, 0, 0);
        fill_a(3, 'h03);
        lk_a(3, 'h02, 1'b0, 0, 0);
        lk_a(3, 'h01, 1'b1, 0, 0);
        lk_a(3, 'h03, 1'b1, 1, 1);

        // Same-cycle lookup and fill: lookup sees pre-fill state
        index_a = 6'd7; tag_a = 6'h10; lookup_en_a = 1'b1; fill_en_a = 1'b1;
        q_a.push_back('{1'b0, 2'd0, 2'd0});
        @(posedge clk);
        #1 lookup_en_a = 1'b0; fill_en_a = 1'b0;
        lk_a(7, 'h10, 1'b1, 0, 1);

        // Full flush sweep
        fill_a(0, 'h05);
        fill_a(63, 'h3F);
        lk_a(63, 'h3F, 1'b1, 0, 1);
        flush_req_a = 1'b1;
        @(posedge clk);
        #1 flush_req_a = 1'b0;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy_a) busy_cnt++;
            if (done_a) begin
                done_cnt++;
                done_at = i;
            end
            if (i == 3) begin
                index_a = 6'd0; tag_a = 6'h05; lookup_en_a = 1'b1;
                q_a.push_back('{1'b0, 2'd0, 2'd0});
            end
            if (i == 4) lookup_en_a = 1'b0;
        end
        chk("flush_busy_cycles", 32'(busy_cnt), 32'd64);
        chk("flush_done_pulses", 32'(done_cnt), 32'd1);
        chk("flush_done_cycle", 32'(done_at), 32'd63);
        chk("busy_after_flush", 32'(busy_a), 32'd0);
        @(posedge clk);
        #1;
        lk_a(0, 'h05, 1'b0, 0, 0);
        lk_a(63, 'h3F, 1'b0, 0, 0);
        lk_a(5, 'h2A, 1'b0, 0, 0);

        // Reset in the middle of a sweep
        fill_a(40, 'h11);
        lk_a(40, 'h11, 1'b1, 0, 1);
        flush_req_a = 1'b1;
        @(posedge clk);
        #1 flush_req_a = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("busy_mid_flush", 32'(busy_a), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_abort_busy", 32'(busy_a), 32'd0);
        chk("rst_abort_done", 32'(done_a), 32'd0);
        chk("rst_abort_hit", 32'(hit_a), 32'd0);
        rst = 1'b0;
        lk_a(40, 'h11, 1'b0, 0, 0);
        chk("idle_after_abort", 32'(busy_a), 32'd0);

        // Four-way true-LRU in set 2
        lk_b(2, 'h11, 1'b0, 0, 0);
        fill_b(2, 'h11);
        fill_b(2, 'h12);
        fill_b(2, 'h13);
        fill_b(2, 'h14);
        lk_b(2, 'h13, 1'b1, 2, 0);
        lk_b(2, 'h11, 1'b1, 0, 0);
        lk_b(2, 'h14, 1'b1, 3, 1);
        lk_b(2, 'h3F, 1'b0, 0, 1);
        fill_b(2, 'h20);
        lk_b(2, 'h12, 1'b0, 0, 2);
        lk_b(2, 'h20, 1'b1, 1, 2);

        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d expected responses never arrived, want 0/0", q_a.size(), q_b.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
